// File: rtl/stm_swapchain_if.sv
//------------------------------------------------------------------------------
// stm_swapchain_if : settings/timer-side bundle for the STM segment sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stm_swapchain_if;
   logic             UPDATE_SETTINGS;
   logic             REQ_RD_SEGMENT;
   logic [1:0][31:0] REP;
   logic [1:0]       TRANSITION_MODE;
   logic [63:0]      TRANSITION_VALUE;
   logic [63:0]      SYS_TIME;
   logic [1:0][15:0] CYCLE;
   logic [1:0][15:0] IDX_IN;
   logic             SEGMENT;
   logic [15:0]      IDX;
   logic             STOP;

   modport master (
      output UPDATE_SETTINGS, REQ_RD_SEGMENT, REP, TRANSITION_MODE,
             TRANSITION_VALUE, SYS_TIME, CYCLE, IDX_IN,
      input  SEGMENT, IDX, STOP
   );

   modport slave (
      input  UPDATE_SETTINGS, REQ_RD_SEGMENT, REP, TRANSITION_MODE,
             TRANSITION_VALUE, SYS_TIME, CYCLE, IDX_IN,
      output SEGMENT, IDX, STOP
   );
endinterface

`default_nettype wire

// File: rtl/stm_swapchain.sv
//------------------------------------------------------------------------------
// stm_swapchain : selects the active STM segment, applies transition modes
//                 and freezes playback after a finite repeat count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stm_swapchain (
   input wire        CLK,
   input wire        RST_N,
   stm_swapchain_if.slave bus
);
   typedef enum logic [2:0] {
      RUN_INF   = 3'd0,
      RUN_FIN   = 3'd1,
      WAIT_IDX  = 3'd2,
      WAIT_TIME = 3'd3,
      STOPPED   = 3'd4
   } state_t;

   localparam logic [1:0]  MODE_SYNC_IDX = 2'd1;
   localparam logic [1:0]  MODE_SYS_TIME = 2'd2;
   localparam logic [31:0] REP_INF       = 32'hFFFF_FFFF;

   state_t           state_q, state_d;
   logic             segment_q, segment_d;
   logic [15:0]      idx_q, idx_d;
   logic             stop_q, stop_d;
   logic             fin_q, fin_d;
   logic [31:0]      loop_cnt_q, loop_cnt_d;
   logic [31:0]      cur_rep_q, cur_rep_d;
   logic             pend_seg_q, pend_seg_d;
   logic [1:0][31:0] rep_q, rep_d;
   logic [63:0]      tvalue_q, tvalue_d;
   logic [1:0][15:0] prev_idx_q;
   logic [1:0]       wrap;
   logic             switch_now;
   logic             switch_seg;

   // A zero-length cycle wraps on every clock.
   for (genvar s = 0; s < 2; s++) begin : g_wrap
      assign wrap[s] = (bus.CYCLE[s] == 16'd0) ||
                       ((prev_idx_q[s] == bus.CYCLE[s]) && (bus.IDX_IN[s] == 16'd0));
   end

   always_comb begin
      state_d    = state_q;
      segment_d  = segment_q;
      stop_d     = stop_q;
      fin_d      = fin_q;
      loop_cnt_d = loop_cnt_q;
      cur_rep_d  = cur_rep_q;
      pend_seg_d = pend_seg_q;
      rep_d      = rep_q;
      tvalue_d   = tvalue_q;
      switch_now = 1'b0;
      switch_seg = pend_seg_q;

      if (bus.UPDATE_SETTINGS) begin
         rep_d      = bus.REP;
         tvalue_d   = bus.TRANSITION_VALUE;
         pend_seg_d = bus.REQ_RD_SEGMENT;
         switch_seg = bus.REQ_RD_SEGMENT;
         if (bus.REQ_RD_SEGMENT == segment_q)
            switch_now = 1'b1;
         else if (bus.TRANSITION_MODE == MODE_SYNC_IDX)
            state_d = WAIT_IDX;
         else if (bus.TRANSITION_MODE == MODE_SYS_TIME)
            state_d = WAIT_TIME;
         else
            switch_now = 1'b1;
      end else if ((state_q == WAIT_IDX) && wrap[pend_seg_q]) begin
         switch_now = 1'b1;
      end else if ((state_q == WAIT_TIME) && (bus.SYS_TIME >= tvalue_q)) begin
         switch_now = 1'b1;
      end else if (fin_q && !stop_q && wrap[segment_q]) begin
         // The old segment keeps counting while a transition is pending.
         loop_cnt_d = loop_cnt_q + 32'd1;
         if (loop_cnt_q == cur_rep_q) begin
            stop_d = 1'b1;
            if (state_q == RUN_FIN)
               state_d = STOPPED;
         end
      end

      if (switch_now) begin
         segment_d  = switch_seg;
         stop_d     = 1'b0;
         loop_cnt_d = 32'd0;
         cur_rep_d  = rep_d[switch_seg];
         fin_d      = (rep_d[switch_seg] != REP_INF);
         state_d    = fin_d ? RUN_FIN : RUN_INF;
      end

      idx_d = stop_d ? bus.CYCLE[segment_d] : bus.IDX_IN[segment_d];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= RUN_INF;
         segment_q  <= 1'b0;
         idx_q      <= 16'd0;
         stop_q     <= 1'b0;
         fin_q      <= 1'b0;
         loop_cnt_q <= 32'd0;
         cur_rep_q  <= 32'd0;
         pend_seg_q <= 1'b0;
         rep_q      <= '0;
         tvalue_q   <= 64'd0;
         prev_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         segment_q  <= segment_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         fin_q      <= fin_d;
         loop_cnt_q <= loop_cnt_d;
         cur_rep_q  <= cur_rep_d;
         pend_seg_q <= pend_seg_d;
         rep_q      <= rep_d;
         tvalue_q   <= tvalue_d;
         prev_idx_q <= bus.IDX_IN;
      end
   end

   assign bus.SEGMENT = segment_q;
   assign bus.IDX     = idx_q;
   assign bus.STOP    = stop_q;

endmodule

`default_nettype wire
